prod_accum: RTL and testbench
=============================

PROD_ACCUM -- requirements
Module: prod_accum

Interface
- REQ-001 SHALL have parameter ACC_W, default 40: accumulator and result width in bits.
- REQ-002 SHALL have parameter LEN_W, default 8: width of the job-length field.
- REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
- REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
- REQ-005 SHALL have port start, input, 1: request to begin a job; sampled only in IDLE.
- REQ-006 SHALL have port len, input, LEN_W: number of products in the job; captured when start is accepted.
- REQ-007 SHALL have port p_valid, input, 1: upstream product valid.
- REQ-008 SHALL have port p_in, input, 32: unsigned 16x16 product from the upstream multiplier stage.
- REQ-009 SHALL have port p_ready, output, 1: block accepts p_in this cycle.
- REQ-010 SHALL have port sum_out, output, ACC_W: accumulated result, stable while sum_valid=1.
- REQ-011 SHALL have port sum_valid, output, 1: result available.
- REQ-012 SHALL have port sum_ready, input, 1: downstream accepts the result.
- REQ-013 SHALL have port ovf, output, 1: saturation occurred during the current or held job.
- REQ-014 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
- REQ-015 SHALL implement the FSM states IDLE, ACCUM and HOLD.
- REQ-016 SHALL, in IDLE with start=1 and len!=0: clear acc and ovf, load cnt=len, and go to ACCUM next cycle.
- REQ-017 SHALL, in IDLE with start=1 and len=0: clear acc and ovf, and go directly to HOLD next cycle (sum_out=0).
- REQ-018 SHALL drive p_ready=1 only in ACCUM; a product transfers when p_valid and p_ready are both 1.
- REQ-019 SHALL, on each transfer, perform acc <= sat(acc + zero-extended p_in) and cnt <= cnt-1.
- REQ-020 SHALL saturate the sum at 2^ACC_W-1 when it overflows, and set ovf sticky until the next accepted start.
- REQ-021 SHALL, on the transfer where cnt=1, go to HOLD next cycle; sum_valid rises the cycle after the last product is accepted (latency 1).
- REQ-022 SHALL, in ACCUM with p_valid=0, hold all state; unlimited bubbles are allowed.
- REQ-023 SHALL, in HOLD, drive sum_valid=1 with sum_out=acc; when sum_ready=1, go to IDLE next cycle with sum_valid=0.
- REQ-024 SHALL ignore start outside IDLE, with no effect on acc, cnt or len.
- REQ-025 SHALL NOT let a start in the same cycle as the HOLD->IDLE handoff begin a job; start is honoured from the following IDLE cycle.
- REQ-026 SHALL support the maximum job len=2^LEN_W-1 without wrap of cnt.
- REQ-027 SHALL drive sum_out from the acc register and p_ready, sum_valid and busy from the state register only; no combinational path from inputs to outputs.

Reset
- REQ-028 SHALL, on rst=1 at a clock edge, set state=IDLE, acc=0, cnt=0, ovf=0; outputs then read p_ready=0, sum_valid=0, sum_out=0, busy=0.
- REQ-029 SHALL let rst mid-job (ACCUM or HOLD) abandon the job with no result emitted.
- REQ-030 SHALL give rst priority over start, p_valid and sum_ready in the same cycle.

Structure
- REQ-031 SHALL place the state enum (IDLE/ACCUM/HOLD) and the defaults ACC_W=40 and LEN_W=8 in shared package prod_accum_pkg.
- REQ-032 SHALL implement the saturating adder (ACC_W + 32 -> ACC_W, sat flag out) as the single combinational sub-module sat_add.
- REQ-033 SHALL use one FSM register, one accumulator register and one down-counter; no FIFOs.

Verification
- REQ-034 SHALL be verified with: start, len=3; products 10, 20, 30 on consecutive cycles -> sum_valid one cycle after the third transfer, sum_out=60, ovf=0.
- REQ-035 SHALL be verified with: len=4 with p_valid gaps of 0-3 cycles between products of 0xFFFFFFFF -> sum_out=0x3FFFFFFFC, p_ready high throughout ACCUM.
- REQ-036 SHALL be verified with: ACC_W=33, len=3, products all 0xFFFFFFFF -> sum_out=0x1FFFFFFFF, ovf=1; ovf clears on the next start.
- REQ-037 SHALL be verified with: sum_ready held 0 for 5 cycles in HOLD -> sum_valid and sum_out stable for all 5 cycles, start pulses ignored; sum_ready=1 -> IDLE next cycle.
- REQ-038 SHALL be verified with: start, len=0 -> HOLD after one cycle with sum_out=0 and p_ready never asserted.
- REQ-039 SHALL be verified with: rst asserted after 2 of 5 products -> next cycle IDLE, all outputs 0; a following job len=1, product 7 -> sum_out=7.

Source files
------------

// File: rtl/prod_accum_pkg.sv
// Shared definitions for the product accumulator: FSM state encodings and
// default widths.
package prod_accum_pkg;

  localparam int ACC_W_DEFAULT = 40;
  localparam int LEN_W_DEFAULT = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t ACCUM = 2'd1;
  localparam state_t HOLD  = 2'd2;

endpackage

// File: rtl/prod_accum_sat_add.sv
// Saturating adder: ACC_W-bit accumulator plus an unsigned 32-bit product.
// The result clamps to all-ones on overflow, and sat flags that the clamp happened.
module sat_add #(
  parameter int ACC_W = 40
) (
  input  logic [ACC_W-1:0] a,
  input  logic [31:0]      b,
  output logic [ACC_W-1:0] sum,
  output logic             sat
);

  // The sum is one bit wider than the wider operand, so the carry out is never lost.
  localparam int W = ((ACC_W > 32) ? ACC_W : 32) + 1;

  logic [W-1:0] full;

  always_comb begin
    full = {{(W-ACC_W){1'b0}}, a} + {{(W-32){1'b0}}, b};
    sat  = |full[W-1:ACC_W];
    sum  = sat ? {ACC_W{1'b1}} : full[ACC_W-1:0];
  end

endmodule

// File: rtl/prod_accum.sv
// Product accumulator: sums len upstream products with saturation, then holds
// the result until the downstream side accepts it.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int LEN_W = LEN_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             p_valid,
  input  logic [31:0]      p_in,
  output logic             p_ready,
  output logic [ACC_W-1:0] sum_out,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             ovf,
  output logic             busy
);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] cnt;
  logic             ovf_q;
  logic [ACC_W-1:0] acc_next;
  logic             acc_sat;

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .a   (acc),
    .b   (p_in),
    .sum (acc_next),
    .sat (acc_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            ovf_q <= 1'b0;
            if (len != '0) begin
              cnt   <= len;
              state <= ACCUM;
            end else begin
              state <= HOLD;
            end
          end
        end
        ACCUM: begin
          if (p_valid) begin
            acc <= acc_next;
            cnt <= cnt - 1'b1;
            if (acc_sat) ovf_q <= 1'b1;
            if (cnt == LEN_W'(1)) state <= HOLD;
          end
        end
        HOLD: begin
          // A start in this cycle is deliberately dropped; only IDLE samples it.
          if (sum_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign p_ready   = (state == ACCUM);
  assign sum_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign sum_out   = acc;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_prod_accum.sv
// Scoreboard bench for prod_accum: a default 40-bit instance and a 33-bit
// instance share one stimulus stream, and each instance's results are checked.
module tb_prod_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        p_valid;
  logic [31:0] p_in;
  logic        sum_ready;

  logic        p_ready, sum_valid, ovf, busy;
  logic [39:0] sum_out;
  logic        p_ready33, sum_valid33, ovf33, busy33;
  logic [32:0] sum_out33;

  typedef struct {
    logic [39:0] s40;
    logic        o40;
    logic [32:0] s33;
    logic        o33;
  } exp_t;

  exp_t        sb[$];
  exp_t        last_exp;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] prod_a[256];
  int          gap_a[256];

  always #5 clk = ~clk;

  prod_accum dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .p_valid(p_valid), .p_in(p_in),
    .p_ready(p_ready), .sum_out(sum_out), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .ovf(ovf), .busy(busy)
  );

  prod_accum #(.ACC_W(33), .LEN_W(8)) dut33 (
    .clk(clk), .rst(rst), .start(start), .len(len), .p_valid(p_valid), .p_in(p_in),
    .p_ready(p_ready33), .sum_out(sum_out33), .sum_valid(sum_valid33), .sum_ready(sum_ready),
    .ovf(ovf33), .busy(busy33)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] sat_model(input logic [63:0] a, input logic [31:0] p,
                                            input int w, output logic o);
    logic [63:0] limit;
    logic [63:0] s;
    limit = (64'd1 << w) - 64'd1;
    s = a + {32'd0, p};
    o = (s > limit);
    return o ? limit : s;
  endfunction

  // Results are checked when the downstream handshake actually happens.
  always @(negedge clk) begin
    if (!rst && sum_valid && sum_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_result", 64'(sum_out), 64'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("sum_out", 64'(sum_out), 64'(e.s40));
        checkOutput("ovf", 64'(ovf), 64'(e.o40));
        checkOutput("sum_out33", 64'(sum_out33), 64'(e.s33));
        checkOutput("ovf33", 64'(ovf33), 64'(e.o33));
      end
    end
  end

  // Start a job, feed n_prod products from prod_a/gap_a, and push the expected
  // result once the job is complete.
  task automatic applyStimulus(input int n_len, input int n_prod);
    logic [63:0] m40, m33;
    logic        o40, o33, t;
    @(posedge clk); #2;
    start = 1'b1;
    len   = n_len[7:0];
    @(posedge clk); #2;
    start = 1'b0;
    m40 = '0; m33 = '0; o40 = 1'b0; o33 = 1'b0;
    for (int i = 0; i < n_prod; i++) begin
      for (int g = 0; g < gap_a[i]; g++) begin
        @(negedge clk);
        checkOutput("p_ready_gap", 64'(p_ready), 64'd1);
        @(posedge clk); #2;
      end
      p_valid = 1'b1;
      p_in    = prod_a[i];
      @(negedge clk);
      checkOutput("p_ready", 64'(p_ready), 64'd1);
      @(posedge clk); #2;
      p_valid = 1'b0;
      m40 = sat_model(m40, prod_a[i], 40, t); o40 = o40 | t;
      m33 = sat_model(m33, prod_a[i], 33, t); o33 = o33 | t;
    end
    if (n_prod == n_len) begin
      last_exp.s40 = m40[39:0];
      last_exp.o40 = o40;
      last_exp.s33 = m33[32:0];
      last_exp.o33 = o33;
      sb.push_back(last_exp);
      @(negedge clk);
      checkOutput("sum_valid_latency", 64'(sum_valid), 64'd1);
      checkOutput("p_ready_in_hold", 64'(p_ready), 64'd0);
      @(posedge clk); #2;
    end
  endtask

  // Keep the result stalled for hold_cycles while pulsing start, then accept it.
  task automatic drainResult(input int hold_cycles);
    sum_ready = 1'b0;
    for (int k = 0; k < hold_cycles; k++) begin
      start = (k % 2 == 0);
      len   = 8'd3;
      @(negedge clk);
      checkOutput("hold_valid", 64'(sum_valid), 64'd1);
      checkOutput("hold_sum", 64'(sum_out), 64'(last_exp.s40));
      checkOutput("hold_sum33", 64'(sum_out33), 64'(last_exp.s33));
      @(posedge clk); #2;
    end
    start     = 1'b1;
    sum_ready = 1'b1;
    @(posedge clk); #2;
    start     = 1'b0;
    sum_ready = 1'b0;
    @(negedge clk);
    checkOutput("handoff_valid", 64'(sum_valid), 64'd0);
    checkOutput("handoff_busy", 64'(busy), 64'd0);
    @(posedge clk); #2;
    @(negedge clk);
    checkOutput("handoff_start_ignored", 64'(busy), 64'd0);
    @(posedge clk); #2;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_p_ready"}, 64'(p_ready), 64'd0);
    checkOutput({tag, "_sum_valid"}, 64'(sum_valid), 64'd0);
    checkOutput({tag, "_sum_out"}, 64'(sum_out), 64'd0);
    checkOutput({tag, "_ovf"}, 64'(ovf), 64'd0);
    checkOutput({tag, "_busy33"}, 64'(busy33), 64'd0);
    checkOutput({tag, "_p_ready33"}, 64'(p_ready33), 64'd0);
    checkOutput({tag, "_sum_valid33"}, 64'(sum_valid33), 64'd0);
  endtask

  initial begin
    // Reset with every other control asserted to show reset wins.
    rst = 1'b1; start = 1'b1; len = 8'd4; p_valid = 1'b1; p_in = 32'd5; sum_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    start = 1'b0; p_valid = 1'b0; sum_ready = 1'b0;
    @(negedge clk);
    checkIdleOutputs("reset");
    @(posedge clk); #2;
    rst = 1'b0;

    $display("[TB] basic job 10+20+30");
    prod_a[0] = 32'd10; prod_a[1] = 32'd20; prod_a[2] = 32'd30;
    for (int i = 0; i < 3; i++) gap_a[i] = 0;
    applyStimulus(3, 3);
    drainResult(0);

    $display("[TB] bubbles between max products, stalled result");
    for (int i = 0; i < 4; i++) begin
      prod_a[i] = 32'hFFFF_FFFF;
      gap_a[i]  = i;
    end
    applyStimulus(4, 4);
    drainResult(5);

    $display("[TB] saturation on the 33-bit instance");
    for (int i = 0; i < 3; i++) begin
      prod_a[i] = 32'hFFFF_FFFF;
      gap_a[i]  = 0;
    end
    applyStimulus(3, 3);
    drainResult(0);

    $display("[TB] zero-length job");
    @(posedge clk); #2;
    start = 1'b1;
    len   = 8'd0;
    @(posedge clk); #2;
    start = 1'b0;
    last_exp.s40 = '0; last_exp.o40 = 1'b0; last_exp.s33 = '0; last_exp.o33 = 1'b0;
    sb.push_back(last_exp);
    @(negedge clk);
    checkOutput("len0_valid", 64'(sum_valid), 64'd1);
    checkOutput("len0_p_ready", 64'(p_ready), 64'd0);
    checkOutput("ovf33_cleared", 64'(ovf33), 64'd0);
    @(posedge clk); #2;
    drainResult(0);

    $display("[TB] reset mid-job");
    for (int i = 0; i < 5; i++) begin
      prod_a[i] = 32'd100 + 32'(i);
      gap_a[i]  = 0;
    end
    applyStimulus(5, 2);
    rst = 1'b1; start = 1'b1; p_valid = 1'b1; p_in = 32'd9; sum_ready = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0; start = 1'b0; p_valid = 1'b0; sum_ready = 1'b0;
    @(negedge clk);
    checkIdleOutputs("midjob_reset");
    @(posedge clk); #2;

    $display("[TB] single-product job after reset");
    prod_a[0] = 32'd7;
    gap_a[0]  = 0;
    applyStimulus(1, 1);
    drainResult(0);

    $display("[TB] maximum-length job with random products");
    for (int i = 0; i < 255; i++) begin
      prod_a[i] = $urandom;
      gap_a[i]  = int'($urandom_range(0, 1));
    end
    applyStimulus(255, 255);
    drainResult(1);

    @(negedge clk);
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
